// File: rtl/rd53_afe_to_ctrl_if.sv
// Signal bundle between the TO front-end controller and its surroundings.
// The controller takes the slave view. Configuration, AFE stimulus and the
// hit-logic side take the master view.
interface rd53_afe_to_ctrl_if #(
  parameter int NCH   = 8,
  parameter int TOT_W = 4,
  parameter int PER_W = 16
);
  logic                   ENABLE;
  logic [NCH-1:0]         POWER_DOWN_MASK;
  logic [PER_W-1:0]       AZ_PERIOD;
  logic                   AZ_REQ;
  logic                   ERR_CLR;
  logic [NCH-1:0]         VOUTP_TO;
  logic [NCH-1:0]         VOUTN_TO;
  logic                   S0;
  logic                   S1;
  logic [NCH-1:0]         POWER_DOWN_TO;
  logic                   AZ_BUSY;
  logic [NCH-1:0]         HIT_VALID;
  logic [NCH*TOT_W-1:0]   HIT_TOT;
  logic [NCH-1:0]         ERR_INVALID;

  modport slave (
    input  ENABLE, POWER_DOWN_MASK, AZ_PERIOD, AZ_REQ, ERR_CLR, VOUTP_TO, VOUTN_TO,
    output S0, S1, POWER_DOWN_TO, AZ_BUSY, HIT_VALID, HIT_TOT, ERR_INVALID
  );

  modport master (
    output ENABLE, POWER_DOWN_MASK, AZ_PERIOD, AZ_REQ, ERR_CLR, VOUTP_TO, VOUTN_TO,
    input  S0, S1, POWER_DOWN_TO, AZ_BUSY, HIT_VALID, HIT_TOT, ERR_INVALID
  );
endinterface

// File: rtl/rd53_afe_to_ctrl.sv
// Digital controller for NCH channels of the Torino synchronous AFE.
// Sequences the shared S0/S1 auto-zero phases (on request or periodically),
// drives per-channel power-down, measures time-over-threshold per channel
// and keeps sticky flags for invalid differential latch states.
module rd53_afe_to_ctrl #(
  parameter int NCH       = 8,
  parameter int TOT_W     = 4,
  parameter int AZ_S0_LEN = 4,
  parameter int AZ_S1_LEN = 4,
  parameter int PER_W     = 16
) (
  input  logic                      CLK_BX,
  input  logic                      RESET,
  rd53_afe_to_ctrl_if.slave         afe
);

  localparam int AZ_MAX_LEN = (AZ_S0_LEN > AZ_S1_LEN) ? AZ_S0_LEN : AZ_S1_LEN;
  localparam int PH_W       = (AZ_MAX_LEN > 1) ? $clog2(AZ_MAX_LEN) : 1;
  localparam logic [PH_W-1:0]  PH_S0_LAST = PH_W'(AZ_S0_LEN - 1);
  localparam logic [PH_W-1:0]  PH_S1_LAST = PH_W'(AZ_S1_LEN - 1);
  localparam logic [TOT_W-1:0] TOT_MAX    = {TOT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AZ_S0 = 2'd1,
    ST_AZ_S1 = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [PH_W-1:0]  r_ph_cnt;
  logic [PH_W-1:0]  w_ph_cnt_next;
  logic [PER_W-1:0] r_per_cnt;
  logic [PER_W-1:0] w_per_cnt_next;

  logic             w_idle;
  logic             w_timer_on;
  logic             w_timer_hit;
  logic             w_trig;
  logic             w_s0;
  logic             w_s1;
  logic             w_busy;

  logic [NCH-1:0]   w_pd_next;
  logic [NCH-1:0]   r_pd;
  logic [NCH-1:0]   r_p;
  logic [NCH-1:0]   r_n;
  logic [NCH-1:0]   w_hit_lvl;
  logic [NCH-1:0]   w_err_set;
  logic [NCH-1:0]   r_err;

  logic [TOT_W-1:0] r_cnt   [NCH];
  logic [TOT_W-1:0] r_tot   [NCH];
  logic             r_valid [NCH];
  logic [NCH-1:0]       w_hit_valid;
  logic [NCH*TOT_W-1:0] w_hit_tot;

  // ---------------------------------------------------------------------
  // Auto-zero trigger: explicit request or period timer, idle and enabled
  // only. A request and a timer expiry on the same edge give one sequence.
  // ---------------------------------------------------------------------
  assign w_idle      = (r_state == ST_IDLE);
  assign w_timer_on  = (afe.AZ_PERIOD != '0);
  assign w_timer_hit = w_timer_on && (r_per_cnt >= (afe.AZ_PERIOD - PER_W'(1)));
  assign w_trig      = w_idle && afe.ENABLE && (afe.AZ_REQ || w_timer_hit);

  // Auto-zero FSM state and phase-length counter
  always_ff @(posedge CLK_BX or posedge RESET) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_ph_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ph_cnt <= w_ph_cnt_next;
    end
  end

  // Next-state and phase-line decode; ENABLE low aborts from any state
  always_comb begin
    w_state_next  = r_state;
    w_ph_cnt_next = r_ph_cnt;
    w_s0          = 1'b0;
    w_s1          = 1'b0;
    w_busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (w_trig) begin
          w_state_next  = ST_AZ_S0;
          w_ph_cnt_next = '0;
        end
      end
      ST_AZ_S0: begin
        w_s0 = 1'b1;
        if (r_ph_cnt == PH_S0_LAST) begin
          w_state_next  = ST_AZ_S1;
          w_ph_cnt_next = '0;
        end else begin
          w_ph_cnt_next = r_ph_cnt + PH_W'(1);
        end
      end
      ST_AZ_S1: begin
        w_s1 = 1'b1;
        if (r_ph_cnt == PH_S1_LAST) begin
          w_state_next  = ST_GUARD;
          w_ph_cnt_next = '0;
        end else begin
          w_ph_cnt_next = r_ph_cnt + PH_W'(1);
        end
      end
      ST_GUARD: begin
        w_state_next  = ST_IDLE;
        w_ph_cnt_next = '0;
      end
      default: begin
        w_state_next  = ST_IDLE;
        w_ph_cnt_next = '0;
      end
    endcase
    if (!afe.ENABLE) begin
      w_state_next  = ST_IDLE;
      w_ph_cnt_next = '0;
    end
  end

  assign afe.S0      = w_s0;
  assign afe.S1      = w_s1;
  assign afe.AZ_BUSY = w_busy;

  // ---------------------------------------------------------------------
  // Period counter: counts enabled idle edges, restarts whenever a sequence
  // starts, the FSM is not idle, or the timer is disabled.
  // ---------------------------------------------------------------------
  always_comb begin
    w_per_cnt_next = r_per_cnt + PER_W'(1);
    if (!afe.ENABLE || !w_timer_on || w_trig || !w_idle) begin
      w_per_cnt_next = '0;
    end
  end

  // Period counter register
  always_ff @(posedge CLK_BX or posedge RESET) begin
    if (RESET) begin
      r_per_cnt <= '0;
    end else begin
      r_per_cnt <= w_per_cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Power-down lines and latch sampling. The sample gate uses the same
  // power-down value that is being registered on this edge, so a channel
  // that powers up delivers real latch data together with its PD bit going
  // low and never shows a stale forced 0/0 while already powered.
  // ---------------------------------------------------------------------
  assign w_pd_next = afe.POWER_DOWN_MASK | {NCH{~afe.ENABLE}};

  // Power-down register and per-channel differential sample registers
  always_ff @(posedge CLK_BX or posedge RESET) begin
    if (RESET) begin
      r_pd <= '1;
      r_p  <= '0;
      r_n  <= '0;
    end else begin
      r_pd <= w_pd_next;
      r_p  <= afe.VOUTP_TO & ~w_pd_next;
      r_n  <= afe.VOUTN_TO & ~w_pd_next;
    end
  end

  assign afe.POWER_DOWN_TO = r_pd;
  assign w_hit_lvl         = r_p & ~r_n;

  // ---------------------------------------------------------------------
  // Invalid differential state: p==n on a powered channel while idle.
  // A new set on the clear edge takes priority over the clear.
  // ---------------------------------------------------------------------
  assign w_err_set = ~(r_p ^ r_n) & ~r_pd & {NCH{w_idle}};

  // Sticky invalid flags
  always_ff @(posedge CLK_BX or posedge RESET) begin
    if (RESET) begin
      r_err <= '0;
    end else begin
      r_err <= (r_err & ~{NCH{afe.ERR_CLR}}) | w_err_set;
    end
  end

  assign afe.ERR_INVALID = r_err;

  // ---------------------------------------------------------------------
  // Per-channel time-over-threshold. Counting is blanked during auto-zero
  // so a hit straddling a sequence start is dropped without a strobe.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_tot
      // Saturating ToT counter, completion strobe and held ToT value
      always_ff @(posedge CLK_BX or posedge RESET) begin
        if (RESET) begin
          r_cnt[gi]   <= '0;
          r_tot[gi]   <= '0;
          r_valid[gi] <= 1'b0;
        end else if (w_busy) begin
          r_cnt[gi]   <= '0;
          r_valid[gi] <= 1'b0;
        end else if (w_hit_lvl[gi]) begin
          r_valid[gi] <= 1'b0;
          if (r_cnt[gi] != TOT_MAX) begin
            r_cnt[gi] <= r_cnt[gi] + TOT_W'(1);
          end
        end else if (r_cnt[gi] != '0) begin
          r_valid[gi] <= 1'b1;
          r_tot[gi]   <= r_cnt[gi];
          r_cnt[gi]   <= '0;
        end else begin
          r_valid[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Pack per-channel results onto the output buses
  always_comb begin
    w_hit_valid = '0;
    w_hit_tot   = '0;
    for (int c = 0; c < NCH; c++) begin
      w_hit_valid[c]               = r_valid[c];
      w_hit_tot[c*TOT_W +: TOT_W]  = r_tot[c];
    end
  end

  assign afe.HIT_VALID = w_hit_valid;
  assign afe.HIT_TOT   = w_hit_tot;

endmodule
